// File: rtl/edu_token_row_sequencer.sv
// Handshaked one-row-per-step token propagation sequencer for the EDU ancilla-qubit rows.
// Optional stall counter output enabled by defining EDU_TOKEN_STALL_CNT_EN.

`ifndef NUM_AQROW
`define NUM_AQROW 8
`endif
`ifndef AQROWADDR_BW
`define AQROWADDR_BW 3
`endif

module edu_token_row_sequencer #(
    parameter int unsigned NUM_COL  = `NUM_AQROW,
    parameter int unsigned COL_BW   = `AQROWADDR_BW,
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned ROW_BW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ROW_BW-1:0] row_sel,
    input  logic [NUM_COL-1:0] row_token_vec,
    output logic              set_valid,
    input  logic              set_ready,
    output logic [NUM_COL-1:0] token_set,
    output logic [NUM_COL-1:0] flag_set,
    output logic              token_exist,
    output logic [COL_BW-1:0] token_col,
    output logic              busy,
    output logic              done
`ifdef EDU_TOKEN_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StEmit,
        StAdvance,
        StDone
    } state_e;

    // The last row is only ever a target, so the final source row is NUM_ROWS-2.
    localparam logic [ROW_BW-1:0] LastSrcRow = ROW_BW'(NUM_ROWS - 2);

    state_e state;

    logic               vec_any;
    logic [COL_BW-1:0]  low_col;
    logic [NUM_COL-1:0] onehot;
    logic [NUM_COL-1:0] therm;

    always_comb begin
        vec_any = |row_token_vec;
        low_col = '0;
        for (int i = int'(NUM_COL) - 1; i >= 0; i--) begin
            if (row_token_vec[i]) begin
                low_col = COL_BW'(i);
            end
        end
        onehot = '0;
        therm  = '0;
        if (vec_any) begin
            onehot[low_col] = 1'b1;
            for (int i = 0; i < int'(NUM_COL); i++) begin
                therm[i] = (i <= int'(low_col));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            row_sel     <= '0;
            set_valid   <= 1'b0;
            token_set   <= '0;
            flag_set    <= '0;
            token_exist <= 1'b0;
            token_col   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            state       <= StIdle;
            row_sel     <= '0;
            set_valid   <= 1'b0;
            token_set   <= '0;
            flag_set    <= '0;
            token_exist <= 1'b0;
            token_col   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StCapture;
                        row_sel <= '0;
                        busy    <= 1'b1;
                    end
                end
                StCapture: begin
                    // Patterns are built straight from the vector so EMIT can drive them registered.
                    token_exist <= vec_any;
                    token_col   <= low_col;
                    token_set   <= onehot;
                    flag_set    <= therm;
                    set_valid   <= 1'b1;
                    state       <= StEmit;
                end
                StEmit: begin
                    if (set_ready) begin
                        set_valid <= 1'b0;
                        token_set <= '0;
                        flag_set  <= '0;
                        state     <= StAdvance;
                    end
                end
                StAdvance: begin
                    if (row_sel == LastSrcRow) begin
                        row_sel <= '0;
                        done    <= 1'b1;
                        state   <= StDone;
                    end else begin
                        row_sel <= row_sel + 1'b1;
                        state   <= StCapture;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef EDU_TOKEN_STALL_CNT_EN
    // Counts back-pressure cycles of the current pass; survives abort, DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == StIdle && start && !abort) begin
            stall_cnt <= '0;
        end else if (set_valid && !set_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/edu_token_row_sequencer.md
Name: edu_token_row_sequencer

Overview:
- Sequences token propagation down the EDU ancilla-qubit rows, one row at a time.
- Per row: selects the row, captures its token vector, priority-encodes the lowest set column, and issues the one-hot token and thermometer flag set patterns to the next row.
- Sits between the EDU top-level control and the per-row token/flag registers; replaces free-running combinational chaining with a handshaked, one-row-per-step schedule.

Parameters:
- NUM_COL, `NUM_AQROW, columns per row (token/flag vector width).
- COL_BW, `AQROWADDR_BW, column index width; must satisfy 2^COL_BW >= NUM_COL.
- NUM_ROWS, 4, rows sequenced per pass; >= 2.
- ROW_BW, 2, row index width; must satisfy 2^ROW_BW >= NUM_ROWS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  pulse; begins a pass, ignored unless IDLE
- abort  input  1  returns FSM to IDLE next cycle from any state
- row_sel  output  ROW_BW  row currently being read
- row_token_vec  input  NUM_COL  token bits of row row_sel, valid same cycle
- set_valid  output  1  token_set/flag_set valid for row row_sel+1
- set_ready  input  1  target row accepts patterns
- token_set  output  NUM_COL  one-hot token pattern
- flag_set  output  NUM_COL  thermometer flag pattern, bits 0..col set
- token_exist  output  1  registered: captured row had a token
- token_col  output  COL_BW  registered lowest set column of captured row
- busy  output  1  FSM not IDLE
- done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: all outputs 0; FSM IDLE; row counter 0.
- States: IDLE, CAPTURE, EMIT, ADVANCE, DONE.
- IDLE: on start, go to CAPTURE with row_sel = 0; busy = 1 from the next cycle.
- CAPTURE (1 cycle):
  - Register token_exist = |row_token_vec.
  - Register token_col = index of lowest set bit of row_token_vec; 0 when none set.
  - Go to EMIT.
- EMIT:
  - set_valid = 1.
  - token_exist = 1: token_set = one-hot at token_col; flag_set has bits [token_col:0] set, all others 0.
  - token_exist = 0: token_set = 0 and flag_set = 0, but set_valid is still asserted (an explicit clear is issued).
  - Patterns and set_valid stay stable while set_valid && !set_ready.
  - Transfer on set_valid && set_ready; then go to ADVANCE.
- ADVANCE (1 cycle):
  - If row_sel == NUM_ROWS-2, go to DONE (last row is target only, never source).
  - Else row_sel += 1 and go to CAPTURE.
- DONE: done = 1 for one cycle; row_sel = 0; go to IDLE.
- Latency: 3 cycles per row with set_ready held high; a pass is 3*(NUM_ROWS-1)+1 cycles from the cycle after start to the done pulse.
- Boundary conditions:
  - Multiple bits set in row_token_vec: lowest index wins.
  - Bit NUM_COL-1 only: flag_set is all ones.
  - start while busy: ignored.
  - abort and start in the same cycle: abort wins; stay or return to IDLE.
  - abort in EMIT: set_valid drops the next cycle without a transfer; outputs and row_sel cleared; no done pulse.
  - set_ready without set_valid: ignored.
  - rst mid-pass: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: EDU_TOKEN_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - Increments in each cycle where set_valid && !set_ready, saturating at 16'hFFFF.
  - Cleared on rst and on each accepted start.
  - Holds its value through DONE and IDLE.
- When undefined: port absent, no counter logic.

Test Plan:
- NUM_COL=8, NUM_ROWS=4, set_ready=1, row_token_vec=8'b0010_0100 for every row, start -> three EMITs with token_set=8'h04 and flag_set=8'h07; done pulses 10 cycles after start.
- Row 0 vec=8'h80, rows 1-2 vec=0 -> first EMIT token_set=8'h80, flag_set=8'hFF; next two EMITs have set_valid=1 with token_set=0 and flag_set=0.
- set_ready held low 5 cycles in the first EMIT -> patterns stable for 6 cycles, done delayed by 5 cycles; with EDU_TOKEN_STALL_CNT_EN, stall_cnt=5.
- abort during the second EMIT -> next cycle busy=0, set_valid=0, row_sel=0; no done pulse; a fresh start runs a full pass.
- start pulsed while busy, and start+abort in the same cycle from IDLE -> no effect on the pass, and the FSM stays IDLE respectively.
- rst asserted asynchronously mid-CAPTURE -> all outputs 0 without a clock edge; a subsequent start behaves as from power-up.
